// File: rtl/fetch_unit.sv
// Instruction fetch unit: internal program memory with a one-cycle registered
// read, a LOAD/RUN control FSM, a prefetch buffer that streams one instruction
// per cycle, and single-cycle redirect handling that discards stale fetches.
module fetch_unit #(
  parameter int                 XLEN      = 32,
  parameter int                 ADDR_W    = 10,
  parameter int                 BUF_DEPTH = 4,
  parameter logic [XLEN-1:0]    RESET_PC  = {XLEN{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [XLEN-1:0]   load_data,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              fetch_busy
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int MEM_DEPTH = 2 ** ADDR_W;

  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [XLEN-1:0]   PC_MASK   = ~(XLEN'(2'b11));
  localparam logic [XLEN-1:0]   PC_STEP   = XLEN'(3'd4);
  localparam logic [XLEN-1:0]   START_PC  = RESET_PC & PC_MASK;
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;

  logic [XLEN-1:0]   mem_r [0:MEM_DEPTH-1];
  logic [XLEN-1:0]   mem_q_r;

  logic              rd_vld_r;
  logic [XLEN-1:0]   rd_pc_r;
  logic [XLEN-1:0]   fetch_pc_r;

  logic [XLEN-1:0]   buf_data_r [0:BUF_DEPTH-1];
  logic [XLEN-1:0]   buf_pc_r   [0:BUF_DEPTH-1];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  logic              issue_s;
  logic              flush_s;
  logic              push_s;
  logic              pop_s;
  logic [XLEN-1:0]   issue_pc_s;
  logic [CNT_W:0]    occ_s;
  logic              inst_valid_s;

  // Occupancy seen by the issue throttle: buffered entries plus the read in flight.
  assign occ_s        = {1'b0, count_r} + {{CNT_W{1'b0}}, rd_vld_r};
  assign inst_valid_s = (state_r == ST_RUN) && (count_r != {CNT_W{1'b0}});

  // State register; reset lands in RUN so fetching starts right away.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: load_mode overrides from any state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (load_mode) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (load_mode) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // Per-state control: read issue, flush, and buffer push/pop strobes.
  always_comb begin
    issue_s    = 1'b0;
    flush_s    = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    issue_pc_s = fetch_pc_r;
    case (state_r)
      ST_RUN: begin
        if (load_mode) begin
          // Leaving for LOAD: nothing new is fetched and the buffer is emptied.
          flush_s = 1'b1;
        end else if (redirect) begin
          // The redirect target is read in the same cycle; older work is dropped.
          flush_s    = 1'b1;
          issue_s    = 1'b1;
          issue_pc_s = redirect_pc & PC_MASK;
        end else begin
          issue_s = (occ_s < DEPTH_C);
          push_s  = rd_vld_r;
          pop_s   = inst_valid_s && inst_ready;
        end
      end
      ST_LOAD: begin
        flush_s = 1'b1;
      end
      default: begin
        flush_s = 1'b1;
      end
    endcase
  end

  // Program memory write port, only open while in LOAD.
  always_ff @(posedge clk) begin
    if ((state_r == ST_LOAD) && load_we) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // Registered memory read; the word address wraps modulo the memory depth.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      mem_q_r <= mem_r[issue_pc_s[ADDR_W+1:2]];
    end
  end

  // Fetch PC and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_r   <= 1'b0;
      rd_pc_r    <= {XLEN{1'b0}};
      fetch_pc_r <= START_PC;
    end else begin
      rd_vld_r <= issue_s;
      if (issue_s) begin
        rd_pc_r    <= issue_pc_s;
        fetch_pc_r <= issue_pc_s + PC_STEP;
      end else if ((state_r == ST_LOAD) || load_mode) begin
        fetch_pc_r <= START_PC;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end
  end

  // Prefetch buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush_s) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end else begin
        head_r <= head_r;
      end
      count_r <= count_r + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
    end
  end

  // Prefetch buffer storage: returned word and its PC land at the tail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      buf_data_r[tail_r] <= mem_q_r;
      buf_pc_r[tail_r]   <= rd_pc_r;
    end
  end

  assign inst_valid = inst_valid_s;
  assign inst       = inst_valid_s ? buf_data_r[head_r] : {XLEN{1'b0}};
  assign inst_pc    = inst_valid_s ? buf_pc_r[head_r]   : {XLEN{1'b0}};
  assign fetch_busy = rd_vld_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue holds the PCs the consumer
// should see in order; the expected instruction comes from a local program copy.
module tb_fetch_unit;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_mode;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [XLEN-1:0]   load_data;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [XLEN-1:0]   inst;
  logic [XLEN-1:0]   inst_pc;
  logic              fetch_busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prog [0:1023];
  logic [31:0] sb_q [$];

  fetch_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .BUF_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .load_mode(load_mode), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every accepted instruction against the next scoreboard entry.
  task automatic monitor();
    logic [31:0] pc;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected observed pc=0x%08h expected no instruction", inst_pc);
      end else begin
        pc = sb_q.pop_front();
        chk("sb_pc", inst_pc, pc);
        chk("sb_inst", inst, prog[pc[11:2]]);
      end
    end
  endtask

  // One clock cycle with the inputs currently applied.
  task automatic tick();
    monitor();
    @(negedge clk);
    #1;
  endtask

  task automatic sb_fill(input logic [31:0] start, input int n);
    sb_q.delete();
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(start + 32'(4 * i));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      prog[i] = 32'hC0DE_0000 | 32'(i);
    end
    prog[0] = 32'h0000_0011;
    prog[1] = 32'h0000_0022;
    prog[2] = 32'h0000_0033;
    prog[3] = 32'h0000_0044;

    reset = 1'b1; load_mode = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    @(negedge clk);
    #1;
    tick();
    tick();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);

    // load_mode in the first post-reset cycle wins over fetching
    reset = 1'b0; load_mode = 1'b1;
    tick();
    chk("load_precedence_busy", 32'(fetch_busy), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      load_we = 1'b1; load_addr = ADDR_W'(i); load_data = prog[i];
      tick();
    end
    load_we = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("load_redirect_valid", 32'(inst_valid), 32'd0);
    chk("load_redirect_busy", 32'(fetch_busy), 32'd0);

    // Exit LOAD with ready high: first valid two cycles later, then one per cycle
    sb_fill(32'h0, 16);
    load_mode = 1'b0; inst_ready = 1'b1;
    tick();
    chk("exit_c0_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("exit_c1_valid", 32'(inst_valid), 32'd0);
    chk("exit_c1_busy", 32'(fetch_busy), 32'd1);
    tick();
    chk("exit_c2_pc", inst_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk("stream_valid", 32'(inst_valid), 32'd1);
      tick();
    end

    // Re-enter LOAD: buffer emptied, nothing fetched
    load_mode = 1'b1; inst_ready = 1'b0;
    tick();
    tick();
    chk("reload_valid", 32'(inst_valid), 32'd0);
    chk("reload_busy", 32'(fetch_busy), 32'd0);

    // Exit with ready low: buffer fills, reads stop, head holds
    sb_fill(32'h0, 16);
    load_mode = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_busy", 32'(fetch_busy), 32'd0);
    chk("full_pc", inst_pc, 32'h0);
    chk("full_inst", inst, 32'h0000_0011);
    tick();
    chk("hold_pc", inst_pc, 32'h0);
    chk("hold_busy", 32'(fetch_busy), 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(inst_valid), 32'd1);
      tick();
    end
    inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("refill_pc", inst_pc, 32'h10);
    chk("refill_busy", 32'(fetch_busy), 32'd0);

    // Redirect to 0x8 while 0x10-0x1C are buffered
    sb_fill(32'h8, 16);
    redirect = 1'b1; redirect_pc = 32'h0000_0008;
    tick();
    redirect = 1'b0; inst_ready = 1'b1;
    chk("redir_c1_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("redir_c2_valid", 32'(inst_valid), 32'd1);
    chk("redir_c2_pc", inst_pc, 32'h8);
    for (int i = 0; i < 3; i++) tick();

    // Redirect coincident with a pop, then a second redirect: only the latter counts
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    chk("pop_redir_valid", 32'(inst_valid), 32'd1);
    tick();
    sb_fill(32'h300, 16);
    redirect_pc = 32'h0000_0300;
    chk("b2b_c1_valid", 32'(inst_valid), 32'd0);
    tick();
    redirect = 1'b0;
    chk("b2b_c2_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("b2b_c3_valid", 32'(inst_valid), 32'd1);
    chk("b2b_c3_pc", inst_pc, 32'h300);
    for (int i = 0; i < 3; i++) tick();

    // Redirect near the top of memory: word address wraps to 0
    redirect = 1'b1; redirect_pc = 32'h0000_0FFC;
    tick();
    sb_fill(32'hFFC, 16);
    redirect = 1'b0;
    tick();
    chk("wrap_pc0", inst_pc, 32'h0000_0FFC);
    chk("wrap_inst0", inst, prog[1023]);
    tick();
    chk("wrap_pc1", inst_pc, 32'h0000_1000);
    chk("wrap_inst1", inst, 32'h0000_0011);
    tick();

    // Reset with entries buffered and a read in flight
    inst_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; inst_ready = 1'b1;
    sb_fill(32'h0, 16);
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_busy", 32'(fetch_busy), 32'd0);
    tick();
    chk("midrst_c1_busy", 32'(fetch_busy), 32'd1);
    tick();
    chk("midrst_c2_valid", 32'(inst_valid), 32'd1);
    chk("midrst_c2_pc", inst_pc, 32'h0);
    for (int i = 0; i < 4; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
